// File: rtl/gpu_pkg.sv
// rtl/gpu_pkg.sv - shared task descriptor types for the dispatcher and processor cores
package gpu_pkg;

  localparam int PC_W   = 16;
  localparam int TID_W  = 8;
  localparam int TASK_W = PC_W + TID_W;

  typedef struct packed {
    logic [PC_W-1:0]  pc;
    logic [TID_W-1:0] tid;
  } task_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with registered count/full/empty and synchronous flush
module sync_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count_next;

  always_comb begin
    count_next = count + (AW+1)'(push) - (AW+1)'(pop);
  end

  assign rdata = mem[rd_ptr];

  // Storage is never reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push && !rst && !flush) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_next;
      empty <= (count_next == '0);
      full  <= (count_next == (AW+1)'(DEPTH));
    end
  end

endmodule

// File: rtl/task_dispatcher.sv
// rtl/task_dispatcher.sv - buffers task descriptors and hands each to one ready core, round-robin
module task_dispatcher #(
  parameter int NUM_CORES = 4,
  parameter int DEPTH     = 8,
  parameter int PC_W      = gpu_pkg::PC_W,
  parameter int TID_W     = gpu_pkg::TID_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [PC_W-1:0]          in_pc,
  input  logic [TID_W-1:0]         in_tid,
  input  logic [NUM_CORES-1:0]     core_ready,
  output logic [NUM_CORES-1:0]     core_valid,
  output logic [PC_W-1:0]          out_pc,
  output logic [TID_W-1:0]         out_tid,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full,
  output logic [31:0]              dispatched
);

  localparam int IDX_W = $clog2(NUM_CORES);

  logic                   push;
  logic                   pop;
  logic                   rr_found;
  logic [IDX_W-1:0]       last_grant;
  logic [IDX_W-1:0]       grant_idx;
  logic [IDX_W:0]         cand;
  logic [PC_W+TID_W-1:0]  head;

  assign in_ready = !full && !rst && !flush;
  assign push     = in_valid && in_ready;
  assign pop      = |(core_valid & core_ready);
  assign {out_pc, out_tid} = head;

  sync_fifo #(
    .WIDTH (PC_W + TID_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (push),
    .pop   (pop),
    .wdata ({in_pc, in_tid}),
    .rdata (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  // Search starts one past the last grant and wraps, so each ready core gets a turn.
  always_comb begin
    rr_found  = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = 1; k <= NUM_CORES; k++) begin
      cand = {1'b0, last_grant} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(NUM_CORES)) cand = cand - (IDX_W+1)'(NUM_CORES);
      if (!rr_found && core_ready[cand[IDX_W-1:0]]) begin
        rr_found  = 1'b1;
        grant_idx = cand[IDX_W-1:0];
      end
    end
  end

  // Offer is withheld during rst/flush so a core never latches a voided transfer.
  always_comb begin
    core_valid = '0;
    if (rr_found && !empty && !rst && !flush) begin
      core_valid[grant_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= IDX_W'(NUM_CORES - 1);
      dispatched <= '0;
    end else if (flush) begin
      last_grant <= IDX_W'(NUM_CORES - 1);
    end else if (pop) begin
      last_grant <= grant_idx;
      dispatched <= dispatched + 32'd1;
    end
  end

endmodule

// File: tb/tb_task_dispatcher.sv
// tb/tb_task_dispatcher.sv - directed stimulus with scoreboard-checked dispatches and status checks
module tb_task_dispatcher;
  import gpu_pkg::*;

  typedef struct {
    int    core;
    task_t t;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_pc;
  logic [7:0]  in_tid;
  logic [3:0]  core_ready;
  logic [3:0]  core_valid;
  logic [15:0] out_pc;
  logic [7:0]  out_tid;
  logic [3:0]  count;
  logic        empty;
  logic        full;
  logic [31:0] dispatched;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  task_dispatcher #(
    .NUM_CORES (4),
    .DEPTH     (8),
    .PC_W      (16),
    .TID_W     (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_pc      (in_pc),
    .in_tid     (in_tid),
    .core_ready (core_ready),
    .core_valid (core_valid),
    .out_pc     (out_pc),
    .out_tid    (out_tid),
    .count      (count),
    .empty      (empty),
    .full       (full),
    .dispatched (dispatched)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_to(input int core, input logic [15:0] pc, input logic [7:0] tid);
    exp_t e;
    e.core   = core;
    e.t.pc   = pc;
    e.t.tid  = tid;
    sb.push_back(e);
  endtask

  task automatic push(input logic [15:0] pc, input logic [7:0] tid);
    in_valid = 1'b1;
    in_pc    = pc;
    in_tid   = tid;
    step();
    in_valid = 1'b0;
  endtask

  // Every handshake seen at the falling edge must match the next expected dispatch.
  always @(negedge clk) begin
    if (|(core_valid & core_ready)) begin
      if (sb.size() == 0) begin
        chk("unexpected_xfer", {28'd0, core_valid}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("xfer_core", {28'd0, core_valid}, 32'd1 << e.core);
        chk("xfer_pc",   {16'd0, out_pc},     {16'd0, e.t.pc});
        chk("xfer_tid",  {24'd0, out_tid},    {24'd0, e.t.tid});
      end
    end
  end

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_pc = '0; in_tid = '0; core_ready = '0;
    step();
    core_ready = 4'b1111;
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_core_valid", {28'd0, core_valid}, 32'd0);
    step();
    rst = 1'b0;
    #1;
    chk("reset_count", {28'd0, count}, 32'd0);
    chk("reset_empty", {31'd0, empty}, 32'd1);
    chk("reset_full", {31'd0, full}, 32'd0);
    chk("reset_dispatched", dispatched, 32'd0);
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);

    // Three back-to-back tasks, all cores ready: cores 0, 1, 2 in turn.
    expect_to(0, 16'h0010, 8'h01);
    expect_to(1, 16'h0020, 8'h02);
    expect_to(2, 16'h0030, 8'h03);
    in_valid = 1'b1; in_pc = 16'h0010; in_tid = 8'h01;
    step();
    in_pc = 16'h0020; in_tid = 8'h02;
    step();
    in_pc = 16'h0030; in_tid = 8'h03;
    step();
    in_valid = 1'b0;
    step();
    step();
    chk("s1_dispatched", dispatched, 32'd3);
    chk("s1_empty", {31'd0, empty}, 32'd1);

    // Fill with no core ready.
    core_ready = 4'b0000;
    for (int i = 0; i < 8; i++) push(16'h0100 + 16'(i), 8'h10 + 8'(i));
    chk("fill_count", {28'd0, count}, 32'd8);
    chk("fill_full", {31'd0, full}, 32'd1);
    chk("fill_in_ready", {31'd0, in_ready}, 32'd0);

    // Full: push offered in the same cycle as a pop to core 3 must be refused.
    expect_to(3, 16'h0100, 8'h10);
    in_valid = 1'b1; in_pc = 16'h01FF; in_tid = 8'hFF; core_ready = 4'b1000;
    #1;
    chk("full_pop_in_ready", {31'd0, in_ready}, 32'd0);
    step();
    in_valid = 1'b0; core_ready = 4'b0000;
    #1;
    chk("after_pop_count", {28'd0, count}, 32'd7);
    chk("after_pop_full", {31'd0, full}, 32'd0);
    chk("after_pop_in_ready", {31'd0, in_ready}, 32'd1);

    // Drain to 4 through core 0, then push+pop at count 4.
    expect_to(0, 16'h0101, 8'h11);
    expect_to(0, 16'h0102, 8'h12);
    expect_to(0, 16'h0103, 8'h13);
    core_ready = 4'b0001;
    step(); step(); step();
    core_ready = 4'b0000;
    #1;
    chk("drain_count", {28'd0, count}, 32'd4);
    expect_to(0, 16'h0104, 8'h14);
    in_valid = 1'b1; in_pc = 16'h0200; in_tid = 8'h20; core_ready = 4'b0001;
    step();
    in_valid = 1'b0; core_ready = 4'b0000;
    #1;
    chk("pushpop_count", {28'd0, count}, 32'd4);
    expect_to(1, 16'h0105, 8'h15);
    expect_to(2, 16'h0106, 8'h16);
    expect_to(3, 16'h0107, 8'h17);
    expect_to(0, 16'h0200, 8'h20);
    core_ready = 4'b1111;
    step(); step(); step(); step();
    core_ready = 4'b0000;
    #1;
    chk("s2_empty", {31'd0, empty}, 32'd1);
    chk("s2_dispatched", dispatched, 32'd12);

    // Make core 1 the last grant, then 1010 gives core 3 then core 1.
    expect_to(1, 16'h0300, 8'h30);
    core_ready = 4'b0010;
    push(16'h0300, 8'h30);
    step();
    core_ready = 4'b0000;
    push(16'h0310, 8'h31);
    push(16'h0320, 8'h32);
    expect_to(3, 16'h0310, 8'h31);
    expect_to(1, 16'h0320, 8'h32);
    core_ready = 4'b1010;
    step(); step();
    core_ready = 4'b0000;
    #1;
    chk("s3_dispatched", dispatched, 32'd15);

    // Flush with 5 queued and every core ready.
    for (int i = 0; i < 5; i++) push(16'h0400 + 16'(i), 8'h40 + 8'(i));
    chk("preflush_count", {28'd0, count}, 32'd5);
    flush = 1'b1; core_ready = 4'b1111;
    #1;
    chk("flush_core_valid", {28'd0, core_valid}, 32'd0);
    chk("flush_in_ready", {31'd0, in_ready}, 32'd0);
    step();
    flush = 1'b0; core_ready = 4'b0000;
    #1;
    chk("flush_count", {28'd0, count}, 32'd0);
    chk("flush_empty", {31'd0, empty}, 32'd1);
    chk("flush_dispatched", dispatched, 32'd15);
    expect_to(0, 16'h0500, 8'h50);
    core_ready = 4'b1111;
    push(16'h0500, 8'h50);
    step();
    core_ready = 4'b0000;
    #1;
    chk("postflush_dispatched", dispatched, 32'd16);

    // Reset while an offer is up.
    push(16'h0600, 8'h60);
    core_ready = 4'b0001;
    #1;
    chk("pre_rst_core_valid", {28'd0, core_valid}, 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_core_valid", {28'd0, core_valid}, 32'd0);
    step();
    rst = 1'b0; core_ready = 4'b0000;
    #1;
    chk("rst2_count", {28'd0, count}, 32'd0);
    chk("rst2_empty", {31'd0, empty}, 32'd1);
    chk("rst2_dispatched", dispatched, 32'd0);
    chk("rst2_in_ready", {31'd0, in_ready}, 32'd1);

    step();
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
